// File: rtl/vote_debounce_filter_pkg.sv
// Shared types and helpers for the vote debounce filter: FSM state encoding
// and the 2-of-3 majority function used to cross-check the upstream detector.
package vote_pkg;

    typedef enum logic [1:0] {
        LO_STABLE = 2'd0,
        PEND_HI   = 2'd1,
        HI_STABLE = 2'd2,
        PEND_LO   = 2'd3
    } vote_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/vote_debounce_filter_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; a synchronous
// clear beats an increment on the same edge.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vote_debounce_filter.sv
// Debounces the majority-detector vote into a stable level with rise/fall
// pulses, counts non-unanimous samples and flags votes that disagree with maj3.
module vote_debounce_filter
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_N = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             vote,
    input  logic             fault_clr,
    output logic             stable,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] fault_count,
    output logic             vote_err
);

    localparam int RUN_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(DEBOUNCE_N);

    vote_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, runInc;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             voteErr_q, voteErr_d;
    logic             nonUnanimous;

    assign runInc       = run_q + RUN_W'(1);
    assign nonUnanimous = (in0 ^ in1) | (in1 ^ in2);

    // In a STABLE state run is zero, so runInc is 1 and DEBOUNCE_N=1 commits at once.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (in_val) begin
            case (state_q)
                LO_STABLE, PEND_HI: begin
                    if (vote) begin
                        if (runInc == RUN_DONE) begin
                            state_d = HI_STABLE;
                            run_d   = '0;
                        end else begin
                            state_d = PEND_HI;
                            run_d   = runInc;
                        end
                    end else begin
                        state_d = LO_STABLE;
                        run_d   = '0;
                    end
                end
                HI_STABLE, PEND_LO: begin
                    if (!vote) begin
                        if (runInc == RUN_DONE) begin
                            state_d = LO_STABLE;
                            run_d   = '0;
                        end else begin
                            state_d = PEND_LO;
                            run_d   = runInc;
                        end
                    end else begin
                        state_d = HI_STABLE;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = LO_STABLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stable_d = (state_d == HI_STABLE) || (state_d == PEND_LO);
        rise_d   = stable_d & ~stable_q;
        fall_d   = ~stable_d & stable_q;
    end

    always_comb begin
        voteErr_d = voteErr_q;
        if (fault_clr) begin
            voteErr_d = 1'b0;
        end else if (in_val && (vote != maj3(in0, in1, in2))) begin
            voteErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LO_STABLE;
            run_q     <= '0;
            stable_q  <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            voteErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            voteErr_q <= voteErr_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_faultCnt (
        .clk  (clk),
        .reset(reset),
        .inc  (in_val & nonUnanimous),
        .clr  (fault_clr),
        .count(fault_count)
    );

    assign stable   = stable_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign vote_err = voteErr_q;

endmodule

// File: tb/tb_vote_debounce_filter.sv
// Directed bench for vote_debounce_filter (DEBOUNCE_N=4, CNT_W=8).
module tb_vote_debounce_filter;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in0, in1, in2;
    logic       vote;
    logic       fault_clr;
    logic       stable, rise, fall, vote_err;
    logic [7:0] fault_count;

    int checks;
    int failures;

    vote_debounce_filter #(
        .DEBOUNCE_N(4),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_val     (in_val),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .vote       (vote),
        .fault_clr  (fault_clr),
        .stable     (stable),
        .rise       (rise),
        .fall       (fall),
        .fault_count(fault_count),
        .vote_err   (vote_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one sample starting #1 after an edge, returns #1 after the next edge.
    task automatic applyStimulus(input logic v, input logic [2:0] ins,
                                 input logic vt, input logic clr);
        in_val    = v;
        in0       = ins[2];
        in1       = ins[1];
        in2       = ins[0];
        vote      = vt;
        fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] majTable;
        logic [2:0] pat;
        checks    = 0;
        failures  = 0;
        majTable  = 8'hE8;
        reset     = 1'b0;
        in_val    = 1'b0;
        in0       = 1'b0;
        in1       = 1'b0;
        in2       = 1'b0;
        vote      = 1'b0;
        fault_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stable", {7'd0, stable}, 8'd0);
        checkOutput("rst_rise", {7'd0, rise}, 8'd0);
        checkOutput("rst_fall", {7'd0, fall}, 8'd0);
        checkOutput("rst_fault", fault_count, 8'd0);
        checkOutput("rst_err", {7'd0, vote_err}, 8'd0);
        reset = 1'b1;

        $display("[TB] async reset mid-run");
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
        checkOutput("pre_fault", fault_count, 8'd1);
        checkOutput("pre_err", {7'd0, vote_err}, 8'd1);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        checkOutput("pend_stable", {7'd0, stable}, 8'd0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_stable", {7'd0, stable}, 8'd0);
        checkOutput("arst_rise", {7'd0, rise}, 8'd0);
        checkOutput("arst_fault", fault_count, 8'd0);
        checkOutput("arst_err", {7'd0, vote_err}, 8'd0);
        reset = 1'b1;
        repeat (3) applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        checkOutput("run_lost_stable", {7'd0, stable}, 8'd0);
        checkOutput("run_lost_rise", {7'd0, rise}, 8'd0);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);

        $display("[TB] debounce rise");
        repeat (3) applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        checkOutput("rise3_stable", {7'd0, stable}, 8'd0);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        checkOutput("rise4_stable", {7'd0, stable}, 8'd1);
        checkOutput("rise4_pulse", {7'd0, rise}, 8'd1);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("rise_end_pulse", {7'd0, rise}, 8'd0);
        checkOutput("rise_end_stable", {7'd0, stable}, 8'd1);
        repeat (4) applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("back_lo_stable", {7'd0, stable}, 8'd0);
        checkOutput("back_lo_fall", {7'd0, fall}, 8'd1);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("back_lo_fall_end", {7'd0, fall}, 8'd0);
        repeat (3) applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("short_stable", {7'd0, stable}, 8'd0);
        checkOutput("short_rise", {7'd0, rise}, 8'd0);

        $display("[TB] gaps inside a run");
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("gap_stable", {7'd0, stable}, 8'd0);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        checkOutput("gap3_stable", {7'd0, stable}, 8'd0);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        checkOutput("gap4_stable", {7'd0, stable}, 8'd1);
        checkOutput("gap4_rise", {7'd0, rise}, 8'd1);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
        checkOutput("gap_hold_stable", {7'd0, stable}, 8'd1);
        checkOutput("gap_hold_rise", {7'd0, rise}, 8'd0);
        repeat (3) applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("fall3_stable", {7'd0, stable}, 8'd1);
        checkOutput("fall3_pulse", {7'd0, fall}, 8'd0);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("fall4_stable", {7'd0, stable}, 8'd0);
        checkOutput("fall4_pulse", {7'd0, fall}, 8'd1);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
        checkOutput("fall_end_pulse", {7'd0, fall}, 8'd0);
        checkOutput("gaps_fault", fault_count, 8'd0);

        $display("[TB] fault counter saturation");
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 3'b011, 1'b1, 1'b0);
        checkOutput("sat_fault", fault_count, 8'd255);
        checkOutput("sat_err", {7'd0, vote_err}, 8'd0);
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b1);
        checkOutput("clr_fault", fault_count, 8'd0);
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
        checkOutput("after_clr_fault", fault_count, 8'd1);
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b1);
        checkOutput("clr_prio_err", {7'd0, vote_err}, 8'd0);
        checkOutput("clr_prio_fault", fault_count, 8'd0);

        $display("[TB] vote cross-check");
        applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
        checkOutput("err_set", {7'd0, vote_err}, 8'd1);
        checkOutput("err_fault", fault_count, 8'd1);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
        checkOutput("err_sticky", {7'd0, vote_err}, 8'd1);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
        checkOutput("err_clr", {7'd0, vote_err}, 8'd0);
        checkOutput("err_clr_fault", fault_count, 8'd0);
        applyStimulus(1'b0, 3'b110, 1'b0, 1'b0);
        checkOutput("err_invalid", {7'd0, vote_err}, 8'd0);
        checkOutput("fault_invalid", fault_count, 8'd0);

        $display("[TB] exhaustive patterns");
        for (int p = 0; p < 8; p++) begin
            pat = 3'(p);
            applyStimulus(1'b1, pat, majTable[pat], 1'b0);
        end
        checkOutput("exh_fault", fault_count, 8'd6);
        checkOutput("exh_err", {7'd0, vote_err}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
